// File: rtl/roic_pkg.sv
// Shared types and defaults for the ROIC frame packer.
package roic_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ACTIVE,
    FLUSH
  } state_t;

  localparam int unsigned ROIC_COLS  = 640;
  localparam int unsigned ROIC_ROWS  = 512;
  localparam int unsigned ROIC_ADC_W = 14;

  // Stream word layout: markers above the sample, MSB first.
  typedef struct packed {
    logic                  sof;
    logic                  eol;
    logic                  eof;
    logic [ROIC_ADC_W-1:0] data;
  } pix_word_t;

  // Counter width for a 0..n-1 range; never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/roic_sync_fifo.sv
// First-word-fall-through synchronous FIFO. DEPTH must be a power of two >= 2.
module roic_sync_fifo #(
  parameter int unsigned WIDTH = 17,
  parameter int unsigned DEPTH = 16
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_push,
  input  logic [WIDTH-1:0]         i_wdata,
  input  logic                     i_pop,
  output logic [WIDTH-1:0]         o_rdata,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic             w_pop;
  logic             w_push;

  assign o_empty = (r_count == '0);
  assign o_full  = (r_count == (AW+1)'(DEPTH));
  assign o_count = r_count;

  // A pop only happens with data present; a pop in the same cycle frees a slot for a push.
  assign w_pop  = i_pop && !o_empty;
  assign w_push = i_push && (!o_full || w_pop);

  // Storage is not reset, so the head is masked to zero while empty.
  assign o_rdata = o_empty ? '0 : r_mem[r_rd_ptr];

  // Write port.
  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_wdata;
  end

  // Pointer and occupancy tracking; pointers wrap naturally at DEPTH.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      if (w_push && !w_pop)      r_count <= r_count + (AW+1)'(1);
      else if (!w_push && w_pop) r_count <= r_count - (AW+1)'(1);
    end
  end

endmodule

// File: rtl/roic_frame_packer.sv
// Tags raster-ordered ADC samples with sof/eol/eof and streams them through a FIFO.
module roic_frame_packer
  import roic_pkg::*;
#(
  parameter int unsigned COLS       = ROIC_COLS,
  parameter int unsigned ROWS       = ROIC_ROWS,
  parameter int unsigned DATA_W     = ROIC_ADC_W,
  parameter int unsigned FIFO_DEPTH = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              frame_start,
  input  logic              adc_valid,
  input  logic [DATA_W-1:0] adc_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DATA_W-1:0] m_data,
  output logic              m_sof,
  output logic              m_eol,
  output logic              m_eof,
  output logic              busy,
  output logic              frame_done,
  output logic              overflow
);

  localparam int unsigned COL_W  = cnt_width(COLS);
  localparam int unsigned ROW_W  = cnt_width(ROWS);
  localparam int unsigned WORD_W = DATA_W + 3;
  localparam int unsigned CNT_W  = $clog2(FIFO_DEPTH) + 1;
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(COLS - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(ROWS - 1);

  state_t           r_state;
  logic [COL_W-1:0] r_col;
  logic [ROW_W-1:0] r_row;
  logic             r_overflow;
  logic             r_frame_done;

  logic              w_sof;
  logic              w_eol;
  logic              w_eof;
  logic              w_push;
  logic              w_pop;
  logic              w_full;
  logic              w_empty;
  logic              w_drained;
  logic [CNT_W-1:0]  w_count;
  logic [WORD_W-1:0] w_wdata;
  logic [WORD_W-1:0] w_rdata;

  assign w_sof   = (r_col == '0) && (r_row == '0);
  assign w_eol   = (r_col == COL_LAST);
  assign w_eof   = w_eol && (r_row == ROW_LAST);
  assign w_push  = (r_state == ACTIVE) && adc_valid;
  assign w_pop   = m_valid && m_ready;
  assign w_wdata = {w_sof, w_eol, w_eof, adc_data};

  // True when the FIFO is empty after this edge, so frame_done lines up with the last pop.
  assign w_drained = w_empty || ((w_count == CNT_W'(1)) && w_pop);

  roic_sync_fifo #(
    .WIDTH (WORD_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .i_clk   (clk),
    .i_rst   (rst),
    .i_push  (w_push),
    .i_wdata (w_wdata),
    .i_pop   (m_ready),
    .o_rdata (w_rdata),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count)
  );

  assign m_valid                        = !w_empty;
  assign {m_sof, m_eol, m_eof, m_data}  = w_rdata;
  assign busy                           = (r_state != IDLE);
  assign frame_done                     = r_frame_done;
  assign overflow                       = r_overflow;

  // Frame FSM with pixel position counters, sticky overflow and completion pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= IDLE;
      r_col        <= '0;
      r_row        <= '0;
      r_overflow   <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      r_frame_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (frame_start) begin
            r_state    <= ACTIVE;
            r_col      <= '0;
            r_row      <= '0;
            r_overflow <= 1'b0;
          end
        end
        ACTIVE: begin
          if (adc_valid) begin
            if (w_full && !w_pop) r_overflow <= 1'b1;
            if (w_eol) begin
              r_col <= '0;
              r_row <= w_eof ? '0 : r_row + ROW_W'(1);
            end else begin
              r_col <= r_col + COL_W'(1);
            end
            if (w_eof) r_state <= FLUSH;
          end
        end
        FLUSH: begin
          if (w_drained) begin
            r_frame_done <= 1'b1;
            r_state      <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_roic_frame_packer.sv
// Bench for roic_frame_packer: small geometry (4x3, depth 4) with vector table and
// corner sequences, plus a wide geometry (640x32, depth 16) against a queue model.
module tb_roic_frame_packer;
  import roic_pkg::*;

  localparam int unsigned S_COLS  = 4;
  localparam int unsigned S_ROWS  = 3;
  localparam int unsigned S_DEPTH = 4;
  localparam int unsigned S_LAST  = S_COLS * S_ROWS - 1;
  localparam int unsigned F_COLS  = 640;
  localparam int unsigned F_ROWS  = 32;
  localparam int unsigned F_DEPTH = 16;
  localparam int unsigned F_TOTAL = F_COLS * F_ROWS;
  localparam int unsigned BUDGET  = 100000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // Small DUT signals
  logic        s_fs = 1'b0, s_av = 1'b0, s_mr = 1'b0;
  logic [13:0] s_ad = '0;
  logic        s_mv, s_sof, s_eol, s_eof, s_busy, s_done, s_ovf;
  logic [13:0] s_md;

  // Wide DUT signals
  logic        f_fs = 1'b0, f_av = 1'b0, f_mr = 1'b0;
  logic [13:0] f_ad = '0;
  logic        f_mv, f_sof, f_eol, f_eof, f_busy, f_done, f_ovf;
  logic [13:0] f_md;

  roic_frame_packer #(
    .COLS (S_COLS), .ROWS (S_ROWS), .DATA_W (14), .FIFO_DEPTH (S_DEPTH)
  ) u_small (
    .clk (clk), .rst (rst), .frame_start (s_fs), .adc_valid (s_av), .adc_data (s_ad),
    .m_valid (s_mv), .m_ready (s_mr), .m_data (s_md), .m_sof (s_sof), .m_eol (s_eol),
    .m_eof (s_eof), .busy (s_busy), .frame_done (s_done), .overflow (s_ovf)
  );

  roic_frame_packer #(
    .COLS (F_COLS), .ROWS (F_ROWS), .DATA_W (14), .FIFO_DEPTH (F_DEPTH)
  ) u_wide (
    .clk (clk), .rst (rst), .frame_start (f_fs), .adc_valid (f_av), .adc_data (f_ad),
    .m_valid (f_mv), .m_ready (f_mr), .m_data (f_md), .m_sof (f_sof), .m_eol (f_eol),
    .m_eof (f_eof), .busy (f_busy), .frame_done (f_done), .overflow (f_ovf)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Push samples k0..k1 with m_ready high; each word must appear one cycle after its push.
  task automatic stream_check(input int k0, input int k1);
    for (int k = k0; k <= k1; k++) begin
      s_av = 1'b1;
      s_ad = 14'(k);
      cyc();
      chk($sformatf("word%0d data", k), s_md, k);
      chk($sformatf("word%0d v/sof/eol/eof", k), {s_mv, s_sof, s_eol, s_eof},
          {1'b1, k == 0, (k % S_COLS) == (S_COLS - 1), k == S_LAST});
    end
    s_av = 1'b0;
  endtask

  task automatic expect_done();
    cyc();
    chk("done/busy/valid at drain", {s_done, s_busy, s_mv}, 3'b100);
    cyc();
    chk("done single pulse", s_done, 0);
  endtask

  typedef struct {
    logic [2:0]  ctl;    // {frame_start, adc_valid, m_ready}
    logic [13:0] ad;
    logic [6:0]  exp_f;  // {m_valid, sof, eol, eof, busy, frame_done, overflow}
    logic [13:0] exp_d;
  } vec_t;

  vec_t tbl [15];

  // Wide-test model state
  pix_word_t q [$];
  pix_word_t w;
  int        issued, cycles, words, eols, eofs, dones;
  logic      exp_ovf;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0]  = '{3'b101, 14'd0,  7'b0000100, 14'd0};
    tbl[1]  = '{3'b011, 14'd0,  7'b1100100, 14'd0};
    tbl[2]  = '{3'b011, 14'd1,  7'b1000100, 14'd1};
    tbl[3]  = '{3'b011, 14'd2,  7'b1000100, 14'd2};
    tbl[4]  = '{3'b011, 14'd3,  7'b1010100, 14'd3};
    tbl[5]  = '{3'b011, 14'd4,  7'b1000100, 14'd4};
    tbl[6]  = '{3'b011, 14'd5,  7'b1000100, 14'd5};
    tbl[7]  = '{3'b011, 14'd6,  7'b1000100, 14'd6};
    tbl[8]  = '{3'b011, 14'd7,  7'b1010100, 14'd7};
    tbl[9]  = '{3'b011, 14'd8,  7'b1000100, 14'd8};
    tbl[10] = '{3'b011, 14'd9,  7'b1000100, 14'd9};
    tbl[11] = '{3'b011, 14'd10, 7'b1000100, 14'd10};
    tbl[12] = '{3'b011, 14'd11, 7'b1011100, 14'd11};
    tbl[13] = '{3'b001, 14'd0,  7'b0000010, 14'd0};
    tbl[14] = '{3'b001, 14'd0,  7'b0000000, 14'd0};

    // Reset values
    repeat (2) @(posedge clk);
    #1;
    chk("reset small outs", {s_mv, s_sof, s_eol, s_eof, s_busy, s_done, s_ovf}, 0);
    chk("reset small data", s_md, 0);
    chk("reset wide outs", {f_mv, f_sof, f_eol, f_eof, f_busy, f_done, f_ovf}, 0);
    rst = 1'b0;
    cyc();

    // Basic frame, vector table
    for (int i = 0; i < 15; i++) begin
      {s_fs, s_av, s_mr} = tbl[i].ctl;
      s_ad = tbl[i].ad;
      cyc();
      chk($sformatf("vec%0d flags", i), {s_mv, s_sof, s_eol, s_eof, s_busy, s_done, s_ovf},
          tbl[i].exp_f);
      chk($sformatf("vec%0d data", i), s_md, tbl[i].exp_d);
    end
    {s_fs, s_av, s_mr} = 3'b000;

    // Backpressure: fill, drop the 5th sample, drain intact, keep geometry
    s_fs = 1'b1; cyc(); s_fs = 1'b0;
    for (int k = 0; k < 5; k++) begin
      s_av = 1'b1;
      s_ad = 14'(k);
      cyc();
      if (k == 3) chk("bp full no ovf yet", s_ovf, 0);
    end
    s_av = 1'b0;
    chk("bp overflow set", s_ovf, 1);
    chk("bp head held", {s_mv, s_md}, {1'b1, 14'd0});
    s_mr = 1'b1;
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("bp drain%0d data", k), s_md, k);
      chk($sformatf("bp drain%0d eol", k), s_eol, k == 3);
      cyc();
    end
    chk("bp drained empty", s_mv, 0);
    stream_check(5, 11);
    expect_done();
    chk("bp overflow sticky", s_ovf, 1);

    // Stall across eof: FLUSH holds until the eof word pops
    s_fs = 1'b1; cyc(); s_fs = 1'b0;
    chk("arm clears overflow", s_ovf, 0);
    stream_check(0, 10);
    s_mr = 1'b0; s_av = 1'b1; s_ad = 14'd11; cyc(); s_av = 1'b0;
    for (int i = 0; i < 10; i++) begin
      chk("flush busy", {s_busy, s_done}, 2'b10);
      cyc();
    end
    chk("flush head held", s_md, 10);
    s_mr = 1'b1; cyc();
    chk("flush eof word", {s_mv, s_eof, s_done, s_busy, s_md}, {4'b1101, 14'd11});
    cyc();
    chk("flush done on last pop", {s_done, s_busy, s_mv}, 3'b100);
    cyc();
    chk("flush done once", s_done, 0);

    // adc_valid in IDLE ignored; frame_start mid-ACTIVE ignored
    s_av = 1'b1; s_ad = 14'd7;
    repeat (3) cyc();
    s_av = 1'b0;
    chk("idle adc ignored", {s_mv, s_busy}, 2'b00);
    s_fs = 1'b1; cyc(); s_fs = 1'b0;
    stream_check(0, 2);
    s_fs = 1'b1; cyc(); s_fs = 1'b0;
    stream_check(3, 11);
    expect_done();

    // Async reset after 6 samples
    s_mr = 1'b0;
    s_fs = 1'b1; cyc(); s_fs = 1'b0;
    for (int k = 0; k < 6; k++) begin
      s_av = 1'b1; s_ad = 14'(k + 100); cyc();
    end
    s_av = 1'b0;
    chk("pre-reset busy/ovf", {s_busy, s_ovf}, 2'b11);
    #2 rst = 1'b1;
    #1;
    chk("async reset outs", {s_mv, s_sof, s_eol, s_eof, s_busy, s_done, s_ovf}, 0);
    chk("async reset data", s_md, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 2; i++) begin
      cyc();
      chk("no done after reset", {s_done, s_busy, s_mv}, 3'b000);
    end
    s_mr = 1'b1;
    s_fs = 1'b1; cyc(); s_fs = 1'b0;
    stream_check(0, 11);
    expect_done();

    // Wide geometry, random valid and stalls, queue model
    issued = 0; cycles = 0; words = 0; eols = 0; eofs = 0; dones = 0; exp_ovf = 1'b0;
    f_fs = 1'b1; cyc(); f_fs = 1'b0;
    chk("wide armed busy", f_busy, 1);
    while (!(issued == F_TOTAL && q.size() == 0) && cycles < BUDGET && n_bad < 40) begin
      chk("rnd valid", f_mv, q.size() != 0);
      if (f_mv && q.size() != 0) chk("rnd word", {f_sof, f_eol, f_eof, f_md}, q[0]);
      if (f_done) dones++;
      f_av = (issued < F_TOTAL) && ($urandom_range(0, 1) == 1);
      f_mr = ($urandom_range(0, 3) != 0);
      f_ad = 14'($urandom);
      if (f_mr && f_mv) begin
        words++;
        if (f_eol) eols++;
        if (f_eof) eofs++;
      end
      if (f_mr && q.size() != 0) void'(q.pop_front());
      if (f_av) begin
        w.sof  = (issued == 0);
        w.eol  = ((issued % F_COLS) == F_COLS - 1);
        w.eof  = (issued == F_TOTAL - 1);
        w.data = f_ad;
        if (q.size() == F_DEPTH) exp_ovf = 1'b1;
        else q.push_back(w);
        issued++;
      end
      cyc();
      cycles++;
    end
    f_av = 1'b0;
    n_cmp++;
    if (cycles >= BUDGET) begin
      n_bad++;
      $display("FAIL rnd budget: got %0d cycles, required fewer than %0d", cycles, BUDGET);
    end
    for (int i = 0; i < 4; i++) begin
      if (f_done) dones++;
      cyc();
    end
    chk("rnd word count", words, F_TOTAL);
    chk("rnd eol count", eols, F_ROWS);
    chk("rnd eof count", eofs, 1);
    chk("rnd done count", dones, 1);
    chk("rnd overflow", f_ovf, exp_ovf);
    chk("rnd idle after", {f_busy, f_mv}, 2'b00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
